// File: rtl/fir_shift_imem_pkg.sv
// Shared FIR constants: sample width, tap count and tap address width.
// The coefficient memory and the MAC datapath use the same package.
package fir_shift_imem_pkg;

  localparam int FIR_DATA_W = 16;
  localparam int FIR_TAPS   = 64;
  localparam int FIR_ADDR_W = 6;

endpackage : fir_shift_imem_pkg

// File: rtl/fir_shift_imem_tap_mux.sv
// DEPTH:1 read mux over the tap array. It is kept as a separate module so
// synthesis can isolate and time the wide combinational select on its own.
module fir_shift_imem_tap_mux
  import fir_shift_imem_pkg::*;
#(
  parameter int DATA_W = FIR_DATA_W,
  parameter int DEPTH  = FIR_TAPS,
  parameter int ADDR_W = FIR_ADDR_W
) (
  input  logic [DATA_W-1:0] taps [DEPTH],
  input  logic [ADDR_W-1:0] sel,
  output logic [DATA_W-1:0] data_out
);

  // Pure combinational select; every sel value addresses a real tap.
  always_comb begin
    data_out = taps[sel];
  end

endmodule : fir_shift_imem_tap_mux

// File: rtl/fir_shift_imem.sv
// Input sample memory for the 64-tap FIR. It is a tapped delay line that
// takes one new sample per clk edge (entry 0 = newest) and has an
// asynchronous, zero-latency read port for the MAC datapath.
// Samples are raw bit patterns. The block does no arithmetic and no sign
// handling.
module fir_shift_imem
  import fir_shift_imem_pkg::*;
#(
  parameter int DATA_W = FIR_DATA_W,
  parameter int DEPTH  = FIR_TAPS,
  parameter int ADDR_W = FIR_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] read_addr,
  output logic [DATA_W-1:0] data_out
);

  logic [DATA_W-1:0] imem [DEPTH];

  // Shift register: clear everything on reset, otherwise load the newest
  // sample at 0 and move each older one up by one entry. The old
  // imem[DEPTH-1] is discarded.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        imem[i] <= '0;
      end
    end else begin
      imem[0] <= data_in;
      for (int i = 1; i < DEPTH; i++) begin
        imem[i] <= imem[i-1];
      end
    end
  end

  fir_shift_imem_tap_mux #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_tap_mux (
    .taps     (imem),
    .sel      (read_addr),
    .data_out (data_out)
  );

endmodule : fir_shift_imem

// File: tb/tb_fir_shift_imem.sv
// Directed bench for fir_shift_imem. The reference model is a sample history
// queue with the newest sample at the front. The expected value for tap a is
// the a-th most recent sample, or 0 if fewer than a+1 samples have arrived
// since reset. Hand-computed literals pin the model at key points.
module tb_fir_shift_imem;

  localparam int DW = 16;
  localparam int DP = 64;
  localparam int AW = 6;

  logic          clk;
  logic          reset;
  logic [DW-1:0] data_in;
  logic [AW-1:0] read_addr;
  logic [DW-1:0] data_out;

  int vectors;
  int miscompares;

  logic [DW-1:0] hist [$];

  fir_shift_imem #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .read_addr (read_addr),
    .data_out  (data_out)
  );

  initial clk = 1'b0;
  always #200 clk = ~clk;

  // Reference history: clear on reset; on each edge out of reset, prepend the sample and keep the last DP.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist.delete();
    end else begin
      hist.push_front(data_in);
      if (hist.size() > DP) void'(hist.pop_back());
    end
  end

  function automatic logic [DW-1:0] model_at(input int a);
    if (a < hist.size()) return hist[a];
    return '0;
  endfunction

  // Continuous compare: after every edge, away from both clock edges, check the current tap against the model.
  always @(posedge clk) begin
    #100;
    vectors++;
    if (data_out !== model_at(int'(read_addr))) begin
      miscompares++;
      $display("FAIL cycle_model addr=%0d got=%h expected=%h", read_addr, data_out, model_at(int'(read_addr)));
    end
  end

  task automatic lit(input string nm, input int a, input logic [DW-1:0] exp_v);
    read_addr = a[AW-1:0];
    #1;
    vectors++;
    if (data_out !== exp_v) begin
      miscompares++;
      $display("FAIL %s addr=%0d got=%h expected=%h", nm, a, data_out, exp_v);
    end
  endtask

  task automatic sweep(input string nm);
    for (int a = 0; a < DP; a++) begin
      read_addr = a[AW-1:0];
      #1;
      vectors++;
      if (data_out !== model_at(a)) begin
        miscompares++;
        $display("FAIL %s addr=%0d got=%h expected=%h", nm, a, data_out, model_at(a));
      end
    end
  endtask

  logic [DW-1:0] fs_vals [3];
  bit found;

  initial begin
    vectors = 0;
    miscompares = 0;
    fs_vals[0] = 16'hFFFF;
    fs_vals[1] = 16'h8000;
    fs_vals[2] = 16'h0000;
    reset = 1'b0;
    data_in = 16'h1234;
    read_addr = 6'd0;

    // Reset held while clk toggles: no shift, all zero.
    repeat (4) @(negedge clk);
    lit("reset_a0", 0, 16'h0000);
    lit("reset_a31", 31, 16'h0000);
    lit("reset_a63", 63, 16'h0000);
    sweep("reset_sweep");

    // Single sample.
    @(negedge clk);
    reset = 1'b1;
    data_in = 16'd100;
    read_addr = 6'd0;
    @(negedge clk);
    data_in = 16'd0;
    lit("single_e1_a0", 0, 16'd100);
    lit("single_e1_a1", 1, 16'd0);
    repeat (5) @(negedge clk);
    lit("single_e6_a5", 5, 16'd100);
    lit("single_e6_a0", 0, 16'd0);
    lit("single_e6_a6", 6, 16'd0);

    // Ramp: sample 100+i on edge i, i = 0..99.
    for (int i = 0; i < 100; i++) begin
      data_in = DW'(100 + i);
      read_addr = AW'(i % DP);
      @(negedge clk);
    end
    lit("ramp_a0", 0, 16'd199);
    lit("ramp_a1", 1, 16'd198);
    lit("ramp_a63", 63, 16'd136);
    found = 1'b0;
    for (int a = 0; a < DP; a++) begin
      read_addr = a[AW-1:0];
      #1;
      if (data_out === 16'd135) found = 1'b1;
    end
    vectors++;
    if (found) begin
      miscompares++;
      $display("FAIL ramp_135_gone got=present expected=absent");
    end

    // Combinational read sweep between edges (memory static in this window).
    @(negedge clk);
    sweep("comb_sweep");

    // Async reset mid-stream, away from any edge.
    @(negedge clk);
    read_addr = 6'd0;
    #50;
    reset = 1'b0;
    #1;
    vectors++;
    if (data_out !== 16'h0000) begin
      miscompares++;
      $display("FAIL async_reset_immediate got=%h expected=%h", data_out, 16'h0000);
    end
    lit("async_reset_a63", 63, 16'h0000);
    lit("async_reset_a1", 1, 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    data_in = 16'hABCD;
    @(negedge clk);
    data_in = 16'h0000;
    lit("post_reset_a0", 0, 16'hABCD);
    lit("post_reset_a1", 1, 16'h0000);
    lit("post_reset_a63", 63, 16'h0000);

    // Full-scale values fed alternately, checked bit-exact across all taps.
    for (int i = 0; i < 70; i++) begin
      data_in = fs_vals[i % 3];
      read_addr = AW'((i * 7) % DP);
      @(negedge clk);
    end
    lit("fs_a0", 0, 16'hFFFF);
    lit("fs_a1", 1, 16'h0000);
    lit("fs_a2", 2, 16'h8000);
    lit("fs_a63", 63, 16'hFFFF);
    lit("fs_a62", 62, 16'h8000);
    sweep("fs_sweep");

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_fir_shift_imem
